multicycle_ctrl: RTL and testbench

//  Multicycle control FSM for the RV64 integer datapath. Sequences fetch/decode/execute/memory/writeback

---
 rtl/multicycle_ctrl_pkg.sv | 62 ++++++
 rtl/multicycle_ctrl_out_decode.sv | 69 ++++++
 rtl/multicycle_ctrl.sv | 94 +++++++++
 tb/tb_multicycle_ctrl.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/multicycle_ctrl_pkg.sv
// Shared definitions for the multicycle control FSM: class bit indices,
// state encodings, pc_src / wb_sel encodings and the decoded output bundle.
package multicycle_ctrl_pkg;

  localparam int CODE_W  = 10;
  localparam int STATE_W = 3;

  // Bit positions inside the one-hot instruction-class code
  localparam int CLS_J     = 0;
  localparam int CLS_JALR  = 1;
  localparam int CLS_LUI   = 2;
  localparam int CLS_AUIPC = 3;
  localparam int CLS_B     = 4;
  localparam int CLS_R     = 5;
  localparam int CLS_S     = 6;
  localparam int CLS_IALU  = 7;
  localparam int CLS_LOAD  = 8;
  localparam int CLS_CSR   = 9;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5
  } state_e;

  typedef enum logic [1:0] {
    PC_PLUS4 = 2'b00,
    PC_ALU   = 2'b01,
    PC_BR    = 2'b10
  } pc_src_e;

  typedef enum logic [1:0] {
    WB_ALU = 2'b00,
    WB_MEM = 2'b01,
    WB_PC4 = 2'b10,
    WB_CSR = 2'b11
  } wb_sel_e;

  typedef struct packed {
    logic    mem_req;
    logic    mem_we;
    logic    mem_addr_sel;
    logic    ir_load;
    logic    pc_load;
    pc_src_e pc_src;
    logic    alu_sel_a;
    logic    alu_sel_b;
    logic    reg_we;
    wb_sel_e wb_sel;
  } ctrl_out_t;

  function automatic logic is_onehot(input logic [CODE_W-1:0] c);
    int unsigned n;
    n = 0;
    for (int i = 0; i < CODE_W; i++) n += 32'(c[i]);
    return n == 1;
  endfunction

endpackage

// File: rtl/multicycle_ctrl_out_decode.sv
// Combinational output decode: (state, latched class, branch_taken, mem_ready)
// to datapath strobes and selects.
module ctrl_out_decode
  import multicycle_ctrl_pkg::*;
#(
  parameter int CODE_W_P = CODE_W
) (
  input  state_e              state_i,
  input  logic [CODE_W_P-1:0] class_q_i,
  input  logic                branch_taken_i,
  input  logic                mem_ready_i,
  output ctrl_out_t           out_o
);

  logic    sel_a, sel_b, is_jump;
  wb_sel_e wb_cls;

  always_comb begin
    sel_a   = class_q_i[CLS_J] | class_q_i[CLS_AUIPC];
    sel_b   = ~(class_q_i[CLS_B] | class_q_i[CLS_R]);
    is_jump = class_q_i[CLS_J] | class_q_i[CLS_JALR];
    wb_cls  = WB_ALU;
    case (1'b1)
      class_q_i[CLS_LOAD]:                      wb_cls = WB_MEM;
      class_q_i[CLS_J], class_q_i[CLS_JALR]:    wb_cls = WB_PC4;
      class_q_i[CLS_CSR]:                       wb_cls = WB_CSR;
      class_q_i[CLS_R], class_q_i[CLS_IALU],
      class_q_i[CLS_LUI], class_q_i[CLS_AUIPC]: wb_cls = WB_ALU;
      default:                                  wb_cls = WB_ALU;
    endcase
  end

  always_comb begin
    out_o = '0;
    case (state_i)
      ST_FETCH: begin
        out_o.mem_req = 1'b1;
        out_o.ir_load = mem_ready_i;
      end
      ST_EXEC: begin
        out_o.alu_sel_a = sel_a;
        out_o.alu_sel_b = sel_b;
        if (class_q_i[CLS_B]) begin
          out_o.pc_load = 1'b1;
          out_o.pc_src  = branch_taken_i ? PC_BR : PC_PLUS4;
        end
      end
      ST_MEM: begin
        // selects keep their EXEC values so the address stays stable
        out_o.mem_req      = 1'b1;
        out_o.mem_addr_sel = 1'b1;
        out_o.mem_we       = class_q_i[CLS_S];
        out_o.alu_sel_a    = sel_a;
        out_o.alu_sel_b    = sel_b;
        out_o.pc_load      = class_q_i[CLS_S] & mem_ready_i;
      end
      ST_WB: begin
        out_o.reg_we    = 1'b1;
        out_o.pc_load   = 1'b1;
        out_o.pc_src    = is_jump ? PC_ALU : PC_PLUS4;
        out_o.wb_sel    = wb_cls;
        out_o.alu_sel_a = sel_a;
        out_o.alu_sel_b = sel_b;
      end
      default: out_o = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle control FSM for the RV64 integer datapath: state register,
// latched instruction class and sticky illegal flag.
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter int CODE_W_P  = CODE_W,
  parameter int STATE_W_P = STATE_W
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [CODE_W_P-1:0]  code,
  input  logic                 mem_ready,
  input  logic                 branch_taken,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic                 mem_addr_sel,
  output logic                 ir_load,
  output logic                 pc_load,
  output logic [1:0]           pc_src,
  output logic                 alu_sel_a,
  output logic                 alu_sel_b,
  output logic                 reg_we,
  output logic [1:0]           wb_sel,
  output logic                 illegal,
  output logic [STATE_W_P-1:0] state
);

  state_e              state_q, state_d;
  logic [CODE_W_P-1:0] class_q, class_d;
  logic                illegal_q, illegal_d;
  ctrl_out_t           dec;

  always_comb begin
    state_d   = state_q;
    class_d   = class_q;
    illegal_d = illegal_q;
    case (state_q)
      ST_FETCH:  if (mem_ready) state_d = ST_DECODE;
      ST_DECODE: begin
        class_d = code;
        if (!is_onehot(code)) begin
          state_d   = ST_HALT;
          illegal_d = 1'b1;
        end else begin
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (class_q[CLS_B])                         state_d = ST_FETCH;
        else if (class_q[CLS_S] | class_q[CLS_LOAD]) state_d = ST_MEM;
        else                                         state_d = ST_WB;
      end
      ST_MEM: if (mem_ready) state_d = class_q[CLS_S] ? ST_FETCH : ST_WB;
      ST_WB:   state_d = ST_FETCH;
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_FETCH;
      class_q   <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      class_q   <= class_d;
      illegal_q <= illegal_d;
    end
  end

  ctrl_out_decode #(.CODE_W_P(CODE_W_P)) u_dec (
    .state_i        (state_q),
    .class_q_i      (class_q),
    .branch_taken_i (branch_taken),
    .mem_ready_i    (mem_ready),
    .out_o          (dec)
  );

  // A reset cycle must not commit architectural state or start a store
  assign mem_req      = dec.mem_req;
  assign mem_we       = dec.mem_we  & ~reset;
  assign mem_addr_sel = dec.mem_addr_sel;
  assign ir_load      = dec.ir_load & ~reset;
  assign pc_load      = dec.pc_load & ~reset;
  assign pc_src       = dec.pc_src;
  assign alu_sel_a    = dec.alu_sel_a;
  assign alu_sel_b    = dec.alu_sel_b;
  assign reg_we       = dec.reg_we  & ~reset;
  assign wb_sel       = dec.wb_sel;
  assign illegal      = illegal_q;
  assign state        = STATE_W_P'(state_q);

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: a per-instruction trace model
// built from the class rules, driven with randomized waits and don't-care inputs.
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       reset, mem_ready, branch_taken;
  logic [9:0] code;
  logic       mem_req, mem_we, mem_addr_sel, ir_load, pc_load;
  logic [1:0] pc_src, wb_sel;
  logic       alu_sel_a, alu_sel_b, reg_we, illegal;
  logic [2:0] state;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic [2:0] st;
    logic req, we, asel, ir, pcl;
    logic [1:0] pcs;
    logic a, b, rwe;
    logic [1:0] wbs;
    logic il;
  } exp_t;

  localparam int J = 0, JALR = 1, LUI = 2, AUIPC = 3, B = 4, R = 5, S = 6, IALU = 7, LOAD = 8, CSR = 9;

  always #5 clk = ~clk;

  multicycle_ctrl dut (
    .clk(clk), .reset(reset), .code(code), .mem_ready(mem_ready), .branch_taken(branch_taken),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr_sel(mem_addr_sel), .ir_load(ir_load),
    .pc_load(pc_load), .pc_src(pc_src), .alu_sel_a(alu_sel_a), .alu_sel_b(alu_sel_b),
    .reg_we(reg_we), .wb_sel(wb_sel), .illegal(illegal), .state(state)
  );

  function automatic exp_t actual();
    return {state, mem_req, mem_we, mem_addr_sel, ir_load, pc_load, pc_src,
            alu_sel_a, alu_sel_b, reg_we, wb_sel, illegal};
  endfunction

  function automatic exp_t mk(input logic [2:0] st, input logic req, we, asel, ir, pcl,
                              input logic [1:0] pcs, input logic a, b, rwe, input logic [1:0] wbs);
    return {st, req, we, asel, ir, pcl, pcs, a, b, rwe, wbs, 1'b0};
  endfunction

  task automatic cyc(input logic rst, input logic rdy, input logic [9:0] c, input logic bt);
    @(negedge clk);
    reset = rst; mem_ready = rdy; code = c; branch_taken = bt;
    #1;
  endtask

  // Builds the expected cycle-by-cycle trace of one instruction from the class
  // rules, drives it, and compares every cycle plus the per-instruction strobe counts.
  task automatic test_instr(input int cls, input bit taken, input int fw, input int mw);
    exp_t q[$];
    bit   rdy[$];
    bit   is_b, is_mem, is_s, jmp, a, b;
    logic [1:0] wbs;
    int   pcl_cnt = 0, rwe_cnt = 0;
    logic [9:0] oh;
    exp_t act;
    is_b = (cls == B); is_s = (cls == S); is_mem = (cls == S) || (cls == LOAD);
    jmp  = (cls == J) || (cls == JALR);
    a    = (cls == J) || (cls == AUIPC);
    b    = !((cls == B) || (cls == R));
    wbs  = (cls == LOAD) ? 2'b01 : jmp ? 2'b10 : (cls == CSR) ? 2'b11 : 2'b00;
    for (int k = 0; k < fw; k++) begin q.push_back(mk(0,1,0,0,0,0,0,0,0,0,0)); rdy.push_back(0); end
    q.push_back(mk(0,1,0,0,1,0,0,0,0,0,0)); rdy.push_back(1);
    q.push_back(mk(1,0,0,0,0,0,0,0,0,0,0)); rdy.push_back(1'($urandom));
    q.push_back(mk(2,0,0,0,0,is_b, (is_b && taken) ? 2'b10 : 2'b00, a, b, 0, 0)); rdy.push_back(1'($urandom));
    if (is_mem) begin
      for (int k = 0; k < mw; k++) begin q.push_back(mk(3,1,is_s,1,0,0,0,a,b,0,0)); rdy.push_back(0); end
      q.push_back(mk(3,1,is_s,1,0,is_s,0,a,b,0,0)); rdy.push_back(1);
    end
    if (!is_b && !is_s) begin
      q.push_back(mk(4,0,0,0,0,1, jmp ? 2'b01 : 2'b00, a, b, 1, wbs)); rdy.push_back(1'($urandom));
    end
    oh = 10'(1) << cls;
    for (int i = 0; i < q.size(); i++) begin
      cyc(0, rdy[i], (q[i].st == 3'd1) ? oh : 10'($urandom),
          (q[i].st == 3'd2) ? taken : 1'($urandom));
      act = actual();
      pcl_cnt += int'(pc_load);
      rwe_cnt += int'(reg_we);
      n_tests++;
      if (act !== q[i]) begin
        n_fail++;
        $display("FAIL instr cls=%0d cyc=%0d: got %b want %b", cls, i, act, q[i]);
      end
      if (reg_we && mem_req) begin
        n_fail++;
        $display("FAIL reg_we_with_mem_req cls=%0d cyc=%0d", cls, i);
      end
    end
    n_tests++;
    if (pcl_cnt !== 1) begin
      n_fail++; $display("FAIL pc_load_count cls=%0d: got %0d want 1", cls, pcl_cnt);
    end
    n_tests++;
    if (rwe_cnt !== ((is_b || is_s) ? 0 : 1)) begin
      n_fail++; $display("FAIL reg_we_count cls=%0d: got %0d want %0d", cls, rwe_cnt, (is_b || is_s) ? 0 : 1);
    end
  endtask

  task automatic test_reset();
    exp_t want;
    cyc(1, 0, 0, 0);
    cyc(1, 1, 0, 0);
    cyc(0, 0, 10'h3ff, 1);
    want = mk(0,1,0,0,0,0,0,0,0,0,0);
    n_tests++;
    if (actual() !== want) begin
      n_fail++; $display("FAIL reset_outputs: got %b want %b", actual(), want);
    end
    n_tests++;
    if (illegal !== 1'b0) begin n_fail++; $display("FAIL reset_illegal: got %b want 0", illegal); end
  endtask

  task automatic test_directed();
    test_instr(R, 0, 0, 0);
    test_instr(LOAD, 0, 0, 3);
    test_instr(B, 1, 0, 0);
    test_instr(B, 0, 2, 0);
    test_instr(J, 0, 0, 0);
    test_instr(LUI, 0, 1, 0);
    test_instr(S, 0, 0, 2);
    test_instr(CSR, 0, 0, 0);
    test_instr(JALR, 0, 0, 0);
    test_instr(AUIPC, 0, 0, 0);
    test_instr(IALU, 0, 0, 0);
  endtask

  task automatic test_illegal(input logic [9:0] bad);
    cyc(0, 1, 10'($urandom), 0);
    cyc(0, 0, bad, 0);
    n_tests++;
    if (state !== 3'd1) begin n_fail++; $display("FAIL illegal_decode_state: got %0d want 1", state); end
    for (int i = 0; i < 10; i++) begin
      cyc(0, 1'($urandom), 10'($urandom), 1'($urandom));
      n_tests++;
      if ({state, illegal, mem_req, mem_we, ir_load, pc_load, reg_we} !== {3'd5, 1'b1, 5'b0}) begin
        n_fail++;
        $display("FAIL halt cyc=%0d: got st=%0d il=%b strobes=%b want st=5 il=1 strobes=0",
                 i, state, illegal, {mem_req, mem_we, ir_load, pc_load, reg_we});
      end
    end
    cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 0);
    n_tests++;
    if ({state, illegal, mem_req} !== {3'd0, 1'b0, 1'b1}) begin
      n_fail++; $display("FAIL halt_reset: got st=%0d il=%b req=%b want st=0 il=0 req=1", state, illegal, mem_req);
    end
  endtask

  task automatic test_store_reset();
    cyc(0, 1, 0, 0);
    cyc(0, 0, 10'(1) << S, 0);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    n_tests++;
    if ({state, mem_we} !== {3'd3, 1'b1}) begin
      n_fail++; $display("FAIL store_mem: got st=%0d we=%b want st=3 we=1", state, mem_we);
    end
    cyc(1, 0, 0, 0);
    n_tests++;
    if ({pc_load, reg_we, mem_we} !== 3'b000) begin
      n_fail++; $display("FAIL store_reset_cycle: got pcl/rwe/we=%b want 000", {pc_load, reg_we, mem_we});
    end
    cyc(0, 0, 0, 0);
    n_tests++;
    if ({state, mem_we, pc_load, reg_we} !== {3'd0, 3'b000}) begin
      n_fail++; $display("FAIL store_after_reset: got st=%0d we/pcl/rwe=%b want st=0 000",
                         state, {mem_we, pc_load, reg_we});
    end
  endtask

  task automatic test_wb_reset();
    cyc(0, 1, 0, 0);
    cyc(0, 0, 10'(1) << R, 0);
    cyc(0, 0, 0, 0);
    cyc(1, 0, 0, 0);
    n_tests++;
    if ({pc_load, reg_we} !== 2'b00) begin
      n_fail++; $display("FAIL wb_reset_cycle: got pcl/rwe=%b want 00", {pc_load, reg_we});
    end
    cyc(0, 0, 0, 0);
    n_tests++;
    if (state !== 3'd0) begin n_fail++; $display("FAIL wb_after_reset: got st=%0d want 0", state); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 60; n++)
      test_instr(int'($urandom_range(9, 0)), 1'($urandom), int'($urandom_range(3, 0)),
                 int'($urandom_range(4, 0)));
  endtask

  initial begin
    reset = 1'b1; mem_ready = 1'b0; code = '0; branch_taken = 1'b0;
    test_reset();
    test_directed();
    test_illegal(10'b0000000011);
    test_illegal(10'b0000000000);
    test_store_reset();
    test_wb_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
